updown_counter_param: RTL

Parametrised up/down counter for the lab board. It is the generalised successor of the fixed 4-bit up/down counter and adds configurable width, a programmable terminal value, wrap or saturate modes, parallel load, count enable with prescaler, and a terminal-count pulse. It drives the LED/counter outputs and one 7-segment digit that shows the count direction ('U' or 'd'). It sits directly behind the board switches/buttons and in front of the LED and segment pins.

---
 rtl/updown_counter_param.sv | 93 +++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with prescaler, wrap/saturate ends, parallel load,
// terminal-count pulse and a registered direction digit ('U'/'d') for the lab board.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0,
    parameter int DIV      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic [7:0]       dir_seg,
    output logic             seg_com
);

    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [7:0]       SEG_U    = 8'b0011_1110;
    localparam logic [7:0]       SEG_D    = 8'b0011_1101;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt;
    logic             step;

    // Loaded values above the terminal value are clamped so out never leaves 0..MAX_VAL.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Returns {terminal, next value}; range ends are compared explicitly, never via overflow.
    function automatic logic [WIDTH:0] step_val(input logic [WIDTH-1:0] v, input logic dir_up);
        logic [WIDTH-1:0] nv;
        logic             term;
        term = 1'b0;
        if (dir_up) begin
            if (v >= MAXV) begin
                term = 1'b1;
                nv   = SATURATE ? MAXV : '0;
            end else begin
                nv = v + WIDTH'(1);
            end
        end else begin
            if (v == '0) begin
                term = 1'b1;
                nv   = SATURATE ? '0 : MAXV;
            end else begin
                nv = v - WIDTH'(1);
            end
        end
        return {term, nv};
    endfunction

    assign step = en && (pre == PRE_LAST);

    always_comb begin
        out_nxt = out;
        pre_nxt = pre;
        tc_nxt  = 1'b0;
        if (load) begin
            out_nxt = clamp_load(load_val);
            pre_nxt = '0;
        end else if (en) begin
            pre_nxt = step ? '0 : pre + PRE_W'(1);
            if (step) begin
                {tc_nxt, out_nxt} = step_val(out, up);
            end
        end
    end

    always_ff @(posedge clk) begin
        dir_seg <= up ? SEG_U : SEG_D;
        if (!rst) begin
            out <= up ? '0 : MAXV;
            pre <= '0;
            tc  <= 1'b0;
        end else begin
            out <= out_nxt;
            pre <= pre_nxt;
            tc  <= tc_nxt;
        end
    end

    assign seg_com = 1'b1;

endmodule
